// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 encryption controller: sequences the permutation rounds, absorbs AD/PT blocks
// over a valid/ready handshake and produces ciphertext blocks and the final tag.
module ascon_ctrl_fsm #(
    parameter int unsigned NB_AD = 1,
    parameter int unsigned NB_PT = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  block_i,
    input  logic         block_valid_i,
    output logic         block_ready_o,
    input  logic [63:0]  state_x0_i,
    input  logic [63:0]  state_x3_i,
    input  logic [63:0]  state_x4_i,
    output logic [3:0]   round_o,
    output logic         input_select_o,
    output logic         ena_xor_up_o,
    output logic [63:0]  data_xor_up_o,
    output logic         ena_xor_down_o,
    output logic [255:0] data_xor_down_o,
    output logic         ena_reg_state_o,
    output logic [63:0]  cipher_o,
    output logic         cipher_valid_o,
    output logic [127:0] tag_o,
    output logic         tag_valid_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [2:0] {
        StIdle, StInit, StWaitAd, StRoundAd, StWaitPt, StRoundPt, StFinal, StTag
    } state_e;

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] LastAd = CntW'(NB_AD - 1);
    localparam logic [CntW-1:0] LastPt = CntW'(NB_PT - 1);
    // Only reachable in the PT phase when NB_PT >= 2.
    localparam logic [CntW-1:0] NextLastPt = CntW'(NB_PT - 2);
    localparam logic [3:0] LastRound = 4'd11;
    localparam logic [3:0] P6First = 4'd6;

    state_e          state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    key_q, key_d;
    logic [63:0]     cipher_q, cipher_d;
    logic            cipher_valid_q, cipher_valid_d;
    logic [127:0]    tag_q, tag_d;
    logic            tag_valid_q, tag_valid_d;

    logic last_ad, last_pt, next_last_pt;

    assign last_ad      = (cnt_q == LastAd);
    assign last_pt      = (cnt_q == LastPt);
    assign next_last_pt = (cnt_q == NextLastPt);

    always_comb begin
        state_d         = state_q;
        round_d         = round_q;
        cnt_d           = cnt_q;
        key_d           = key_q;
        cipher_d        = cipher_q;
        cipher_valid_d  = 1'b0;
        tag_d           = tag_q;
        tag_valid_d     = 1'b0;
        round_o         = round_q;
        input_select_o  = 1'b0;
        ena_xor_up_o    = 1'b0;
        ena_xor_down_o  = 1'b0;
        data_xor_down_o = '0;
        ena_reg_state_o = 1'b0;
        block_ready_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    key_d   = key_i;
                    round_d = 4'd0;
                    cnt_d   = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                ena_reg_state_o = 1'b1;
                input_select_o  = (round_q == 4'd0);
                round_d         = round_q + 4'd1;
                if (round_q == LastRound) begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_q};
                    round_d         = 4'd0;
                    cnt_d           = '0;
                    state_d         = StWaitAd;
                end
            end
            StWaitAd: begin
                block_ready_o = 1'b1;
                // The accept cycle already runs the first p6 round.
                if (block_valid_i) begin
                    round_o         = P6First;
                    ena_xor_up_o    = 1'b1;
                    ena_reg_state_o = 1'b1;
                    round_d         = P6First + 4'd1;
                    state_d         = StRoundAd;
                end
            end
            StRoundAd: begin
                ena_reg_state_o = 1'b1;
                round_d         = round_q + 4'd1;
                if (round_q == LastRound) begin
                    round_d = 4'd0;
                    if (last_ad) begin
                        ena_xor_down_o  = 1'b1;
                        data_xor_down_o = 256'h1
                                        | ((NB_PT == 1) ? {key_q, 128'h0} : 256'h0);
                        cnt_d           = '0;
                        state_d         = StWaitPt;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StWaitAd;
                    end
                end
            end
            StWaitPt: begin
                block_ready_o = 1'b1;
                if (block_valid_i) begin
                    ena_xor_up_o    = 1'b1;
                    ena_reg_state_o = 1'b1;
                    cipher_d        = state_x0_i ^ block_i;
                    cipher_valid_d  = 1'b1;
                    if (last_pt) begin
                        round_o = 4'd0;
                        round_d = 4'd1;
                        state_d = StFinal;
                    end else begin
                        round_o = P6First;
                        round_d = P6First + 4'd1;
                        state_d = StRoundPt;
                    end
                end
            end
            StRoundPt: begin
                ena_reg_state_o = 1'b1;
                round_d         = round_q + 4'd1;
                if (round_q == LastRound) begin
                    if (next_last_pt) begin
                        ena_xor_down_o  = 1'b1;
                        data_xor_down_o = {key_q, 128'h0};
                    end
                    round_d = 4'd0;
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = StWaitPt;
                end
            end
            StFinal: begin
                ena_reg_state_o = 1'b1;
                round_d         = round_q + 4'd1;
                if (round_q == LastRound) begin
                    round_d = 4'd0;
                    state_d = StTag;
                end
            end
            StTag: begin
                tag_d       = {state_x3_i, state_x4_i} ^ key_q;
                tag_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q        <= StIdle;
            round_q        <= 4'd0;
            cnt_q          <= '0;
            key_q          <= '0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
            tag_q          <= '0;
            tag_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            cnt_q          <= cnt_d;
            key_q          <= key_d;
            cipher_q       <= cipher_d;
            cipher_valid_q <= cipher_valid_d;
            tag_q          <= tag_d;
            tag_valid_q    <= tag_valid_d;
        end
    end

    assign data_xor_up_o  = block_i;
    assign cipher_o       = cipher_q;
    assign cipher_valid_o = cipher_valid_q;
    assign tag_o          = tag_q;
    assign tag_valid_o    = tag_valid_q;
    assign done_o         = tag_valid_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: directed control checks, an attached Ascon datapath model for
// known-answer runs with stalls, and synchronous reset during INIT and mid-p6.
module tb_ascon_ctrl_fsm;

    localparam int NPT = 4;
    localparam logic [127:0] KA = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] KK = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         resetb, start, block_valid, block_ready;
    logic [127:0] key;
    logic [63:0]  block;
    logic [63:0]  x0_in, x3_in, x4_in;
    logic [3:0]   round;
    logic         input_select, ena_up, ena_down, ena_reg;
    logic [63:0]  data_up;
    logic [255:0] data_down;
    logic [63:0]  cipher;
    logic         cipher_valid, tag_valid, busy, done;
    logic [127:0] tag;

    logic [319:0] dp = '0;
    logic [319:0] init_state;
    logic         use_dp;
    logic [63:0]  x0_f, x3_f, x4_f;
    logic [63:0]  kat_ad;
    logic [63:0]  kat_pt [NPT];
    logic [63:0]  ref_c [NPT];
    logic [127:0] ref_t;

    logic [63:0]  cq[$];
    logic [127:0] tq[$];
    int           nvec = 0;
    int           nerr = 0;
    bit           tag_seen;

    always #5 clk = ~clk;

    assign x0_in = use_dp ? dp[319:256] : x0_f;
    assign x3_in = use_dp ? dp[127:64]  : x3_f;
    assign x4_in = use_dp ? dp[63:0]    : x4_f;

    ascon_ctrl_fsm #(.NB_AD(1), .NB_PT(NPT)) dut (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .key_i(key),
        .block_i(block), .block_valid_i(block_valid), .block_ready_o(block_ready),
        .state_x0_i(x0_in), .state_x3_i(x3_in), .state_x4_i(x4_in),
        .round_o(round), .input_select_o(input_select),
        .ena_xor_up_o(ena_up), .data_xor_up_o(data_up),
        .ena_xor_down_o(ena_down), .data_xor_down_o(data_down),
        .ena_reg_state_o(ena_reg), .cipher_o(cipher), .cipher_valid_o(cipher_valid),
        .tag_o(tag), .tag_valid_o(tag_valid), .busy_o(busy), .done_o(done)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] rnd(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'h0, 4'hf - r, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Registered permutation datapath driven by the controller outputs.
    always @(posedge clk) begin : dp_upd
        logic [319:0] s;
        s = input_select ? init_state : dp;
        if (ena_up) s[319:256] = s[319:256] ^ data_up;
        s = rnd(s, round);
        if (ena_down) s[255:0] = s[255:0] ^ data_down;
        if (ena_reg) dp <= s;
    end

    // Algorithmic Ascon-128 encryption used as the known-answer reference.
    task automatic ref_model();
        logic [319:0] s;
        s = init_state;
        for (int r = 0; r < 12; r++) s = rnd(s, 4'(r));
        s[127:0] = s[127:0] ^ KK;
        s[319:256] = s[319:256] ^ kat_ad;
        for (int r = 6; r < 12; r++) s = rnd(s, 4'(r));
        s[0] = s[0] ^ 1'b1;
        for (int i = 0; i < NPT; i++) begin
            ref_c[i] = s[319:256] ^ kat_pt[i];
            s[319:256] = ref_c[i];
            if (i < NPT - 1) begin
                for (int r = 6; r < 12; r++) s = rnd(s, 4'(r));
                if (i == NPT - 2) s[255:128] = s[255:128] ^ KK;
            end else begin
                for (int r = 0; r < 12; r++) s = rnd(s, 4'(r));
            end
        end
        ref_t = s[127:0] ^ KK;
    endtask

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and score any output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cipher_valid) begin
            if (cq.size() == 0) chk("cipher_spurious", {255'h0, cipher_valid}, 256'h0);
            else chk("cipher", {192'h0, cipher}, {192'h0, cq.pop_front()});
        end
        if (tag_valid || done) begin
            chk("done_with_tag", {255'h0, done}, {255'h0, tag_valid});
            if (tq.size() == 0) chk("tag_spurious", {255'h0, tag_valid}, 256'h0);
            else chk("tag", {128'h0, tag}, {128'h0, tq.pop_front()});
            tag_seen = 1'b1;
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_ctrl"}, {242'h0, round, input_select, ena_up, ena_down, ena_reg,
            block_ready, cipher_valid, tag_valid, busy, done, 1'b0}, 256'h0);
        chk({pfx, "_mask"}, data_down, 256'h0);
        chk({pfx, "_cipher"}, {192'h0, cipher}, 256'h0);
        chk({pfx, "_tag"}, {128'h0, tag}, 256'h0);
    endtask

    task automatic send_block(input logic [63:0] data, input int stall, input bit push,
                              input logic [63:0] expv);
        int n;
        block = data;
        block_valid = (stall == 0);
        #1;
        n = 0;
        while (!block_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", {255'h0, block_ready}, 256'h1);
        repeat (stall) begin
            chk("stall_hold", {255'h0, ena_reg}, 256'h0);
            tick();
        end
        block_valid = 1'b1;
        #1;
        if (push) cq.push_back(expv);
        tick();
        block_valid = 1'b0;
    endtask

    task automatic run_kat(input int stall);
        int n;
        use_dp = 1'b1;
        key = KK;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_block(kat_ad, stall, 1'b0, 64'h0);
        for (int b = 0; b < NPT; b++) begin
            if (b == NPT - 1) tq.push_back(ref_t);
            send_block(kat_pt[b], stall, 1'b1, ref_c[b]);
        end
        tag_seen = 1'b0;
        n = 0;
        while (!tag_seen && n < 40) begin
            tick();
            n++;
        end
        chk("kat_tag_seen", {255'h0, tag_seen}, 256'h1);
        chk("kat_idle", {255'h0, busy}, 256'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        init_state = {64'h80400c0600000000, KK, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f};
        kat_ad = 64'h4153434f4e2d4144;
        kat_pt[0] = 64'h0011223344556677;
        kat_pt[1] = 64'h8899aabbccddeeff;
        kat_pt[2] = 64'hdeadbeefcafef00d;
        kat_pt[3] = 64'h8000000000000000;
        ref_model();

        use_dp = 1'b0;
        x0_f = 64'haaaaaaaaaaaaaaaa;
        x3_f = 64'h0;
        x4_f = 64'h0;
        resetb = 1'b0;
        start = 1'b0;
        key = KA;
        block = 64'h0;
        block_valid = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");
        resetb = 1'b1;

        // Directed pass; block_valid held high so the AD block is taken on the first ready.
        block = 64'h8000000000000000;
        block_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("init_round", {252'h0, round}, 256'(i));
            chk("init_sel", {255'h0, input_select}, {255'h0, i == 0});
            chk("init_ena_reg_ready", {254'h0, ena_reg, block_ready}, 256'h2);
            chk("init_down_en", {255'h0, ena_down}, {255'h0, i == 11});
            chk("init_down_mask", data_down, (i == 11) ? {128'h0, KA} : 256'h0);
            tick();
        end
        chk("ad_accept", {252'h0, block_ready, ena_up, ena_reg, busy}, 256'hf);
        chk("ad_round", {252'h0, round}, 256'h6);
        chk("ad_up_data", {192'h0, data_up}, {192'h0, 64'h8000000000000000});
        tick();
        block_valid = 1'b0;
        for (int r = 7; r < 12; r++) begin
            chk("ad_round", {252'h0, round}, 256'(r));
            chk("ad_ena_reg", {255'h0, ena_reg}, 256'h1);
            chk("ad_down_en", {255'h0, ena_down}, {255'h0, r == 11});
            chk("ad_mask", data_down, (r == 11) ? 256'h1 : 256'h0);
            tick();
        end

        block = 64'h5555555555555555;
        for (int b = 0; b < NPT; b++) begin
            block_valid = 1'b1;
            #1;
            chk("pt_ready", {254'h0, block_ready, ena_up}, 256'h3);
            chk("pt_round", {252'h0, round}, (b == NPT - 1) ? 256'h0 : 256'h6);
            cq.push_back(64'hffffffffffffffff);
            tick();
            block_valid = 1'b0;
            if (b < NPT - 1) begin
                for (int r = 7; r < 12; r++) begin
                    chk("pt_round", {252'h0, round}, 256'(r));
                    chk("pt_down_en", {255'h0, ena_down}, {255'h0, r == 11 && b == NPT - 2});
                    chk("pt_mask", data_down,
                        (r == 11 && b == NPT - 2) ? {KA, 128'h0} : 256'h0);
                    tick();
                end
            end else begin
                for (int r = 1; r < 12; r++) begin
                    chk("final_round", {252'h0, round}, 256'(r));
                    chk("final_reg_down", {254'h0, ena_reg, ena_down}, 256'h2);
                    tick();
                end
            end
        end
        chk("tag_state", {253'h0, busy, ena_reg, tag_valid}, 256'h4);
        tq.push_back(KA);
        tag_seen = 1'b0;
        tick();
        chk("tag_seen_13", {255'h0, tag_seen}, 256'h1);
        chk("busy_after_tag", {255'h0, busy}, 256'h0);
        tick();
        chk("tag_pulse_once", {254'h0, tag_valid, done}, 256'h0);
        chk("tag_held", {128'h0, tag}, {128'h0, KA});

        // Reset during INIT round 3 with start asserted.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("init_r3", {252'h0, round}, 256'h3);
        resetb = 1'b0;
        start = 1'b1;
        tick();
        chk_reset_state("rst_init");
        tick();
        chk_reset_state("rst_init_hold");
        resetb = 1'b1;
        start = 1'b0;
        tick();
        chk("rst_init_idle", {255'h0, busy}, 256'h0);

        run_kat(0);
        run_kat(1);
        run_kat(5);

        // Reset in the middle of an AD p6.
        use_dp = 1'b1;
        key = KK;
        block = kat_ad;
        block_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("p6_r8", {252'h0, round}, 256'h8);
        resetb = 1'b0;
        start = 1'b1;
        tick();
        chk_reset_state("rst_p6");
        tick();
        chk_reset_state("rst_p6_hold");
        resetb = 1'b1;
        start = 1'b0;
        block_valid = 1'b0;
        tick();
        chk("rst_p6_idle", {255'h0, busy}, 256'h0);

        chk("cipher_queue_drained", 256'(cq.size()), 256'h0);
        chk("tag_queue_drained", 256'(tq.size()), 256'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
